// File: rtl/logic_op_unit_pkg.sv
// Shared definitions for the logic operation unit: op encodings and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_op_unit_pkg;

`include "logic_op_defs.vh"

    localparam int OP_W = 3;

    // True for every encoding that maps to a real bitwise operation.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op != OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise operator selected by op; flags the illegal encoding.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when to register the result.
module logic_op_core
    import logic_op_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    // Select the bitwise result; the illegal encoding yields all zeros.
    always_comb begin
        y       = '0;
        illegal = !op_is_legal(op);
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_defs.vh
// Operation encodings shared by the RTL and the testbench.
// Included inside logic_op_unit_pkg so every importer sees the same constants.
// Guarded so a second inclusion in the same compilation unit is harmless.
`ifndef LOGIC_OP_DEFS_VH
`define LOGIC_OP_DEFS_VH
localparam logic [2:0] OP_AND     = 3'd0;
localparam logic [2:0] OP_OR      = 3'd1;
localparam logic [2:0] OP_NAND    = 3'd2;
localparam logic [2:0] OP_NOR     = 3'd3;
localparam logic [2:0] OP_XOR     = 3'd4;
localparam logic [2:0] OP_XNOR    = 3'd5;
localparam logic [2:0] OP_NOT     = 3'd6;
localparam logic [2:0] OP_ILLEGAL = 3'd7;
`endif

// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit with valid/ready handshake, sticky err and saturating txn counter.
// Latency: 1 cycle from accept to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready drops while a result is held and out_ready is low. Macro LOGIC_OP_REDUCE_EN adds y_red.
module logic_op_unit
    import logic_op_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef LOGIC_OP_REDUCE_EN
    output logic [2:0]       y_red,
`endif
    output logic             err,
    output logic [CNT_W-1:0] txn_count,
    input  logic             clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] core_y;
    logic             core_illegal;
    logic             accept;
    logic             out_hs;

    logic [WIDTH-1:0] y_q;
    logic             vld_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op      (op),
        .a       (a),
        .b       (b),
        .y       (core_y),
        .illegal (core_illegal)
    );

    // Ready whenever the output slot is empty or being drained this cycle; never during reset.
    always_comb begin
        in_ready = rst_n && (!vld_q || out_ready);
        accept   = in_valid && in_ready;
        out_hs   = vld_q && out_ready;
    end

    // Output slot: load on accept, empty on a handshake without a refill, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (accept) begin
            y_q   <= core_y;
            vld_q <= 1'b1;
        end else if (out_hs) begin
            vld_q <= 1'b0;
        end
    end

    // Sticky illegal-op flag; an illegal accept in the same cycle as clr still sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && core_illegal) begin
            err_q <= 1'b1;
        end else if (clr) begin
            err_q <= 1'b0;
        end
    end

    // Count completed output handshakes, saturating; clr takes priority over a count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (out_hs && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef LOGIC_OP_REDUCE_EN
    logic [2:0] red_q;

    // Reduction bits of the result travel with y and obey the same hold rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q <= '0;
        end else if (accept) begin
            red_q <= {^core_y, |core_y, &core_y};
        end
    end

    assign y_red = red_q;
`endif

    assign y         = y_q;
    assign out_valid = vld_q;
    assign err       = err_q;
    assign txn_count = cnt_q;

endmodule

// File: doc/logic_op_unit.md
LOGIC_OP_UNIT -- requirements
Module: logic_op_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width (legal 1..64).
REQ-002 Parameter CNT_W, default 16, transaction counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand bundle valid.
REQ-006 in_ready  output  1  unit can accept bundle this cycle.
REQ-007 op  input  3  operation select (encoding in REQ-013).
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B (ignored for NOT).
REQ-010 out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 y  output  WIDTH  registered result; err  output  1  sticky illegal-op flag; txn_count  output  CNT_W  completed results.
REQ-012 clr  input  1  synchronous clear of txn_count and err.

Function
REQ-013 Op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 illegal; all ops are bitwise across WIDTH.
REQ-014 Accept on rising edge when in_valid && in_ready; y and out_valid update on that edge (latency 1 cycle).
REQ-015 in_ready = rst_n && (!out_valid || out_ready), combinational; no combinational path from a/b/op to any output.
REQ-016 Output held stable (y unchanged, out_valid high) while out_valid && !out_ready.
REQ-017 Output handshake out_valid && out_ready with no new accept -> out_valid 0 next cycle, y holds last value.
REQ-018 Simultaneous output handshake and input accept -> out_valid stays 1, y takes new result; no bubble.
REQ-019 Illegal op 7 accepted -> y = 0, out_valid asserted normally, err set next edge.
REQ-020 err is sticky; on a cycle with both clr and an illegal accept, set wins (err = 1).
REQ-021 txn_count increments by 1 per output handshake; saturates at 2^CNT_W-1, no wrap.
REQ-022 clr and output handshake in same cycle -> txn_count = 0 (clear wins).
REQ-023 in_valid without in_ready: bundle not captured, no state change.

Reset
REQ-024 rst_n low asynchronously forces out_valid 0, y 0, err 0, txn_count 0, y_red 0; in_ready 0 while rst_n low.
REQ-025 Reset mid-transaction discards the pending result; no output handshake is counted.
REQ-026 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro LOGIC_OP_REDUCE_EN defined -> extra output y_red[2:0] = {^result, |result, &result}, registered alongside y with identical timing and hold rules.
REQ-028 Macro undefined -> y_red port and its registers absent; all other behaviour identical.

Structure
REQ-029 Op encoding constants (OP_AND..OP_ILLEGAL, width 3) live in shared header logic_op_defs.vh, used by RTL and bench.
REQ-030 Combinational sub-module logic_op_core (ports op, a, b, y, illegal) computes the bitwise result; logic_op_unit holds handshake, registers, counter, err.

Verification (WIDTH=8, CNT_W=4)
REQ-031 Each op 0..6 with a=8'hA5, b=8'h3C, out_ready=1 -> y next cycle = 24,BD,DB,42,99,66,5A respectively; txn_count = 7.
REQ-032 out_ready=0 for 3 cycles after an accept -> y/out_valid held, in_ready=0, second bundle not captured until out_ready=1.
REQ-033 Continuous in_valid and out_ready for 20 bundles -> one result per cycle, no bubbles, txn_count saturates at 4'hF.
REQ-034 op=7 accepted together with clr=1 -> y=8'h00, err=1, txn_count=0.
REQ-035 rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid, y, err, txn_count all 0 immediately, no counted handshake.
REQ-036 With LOGIC_OP_REDUCE_EN, op=0 a=8'hFF b=8'hFF -> y_red=3'b011; a=8'h01 b=8'h00 op=1 -> y_red=3'b110.
